// File: rtl/mul_pkg.sv
// Shared constants and types for the memory-mapped 64x64 signed multiplier.
package mul_pkg;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 16;
    localparam int MUL_STEPS = 64;

    // Byte offsets within the slave window; only addr[5:3] selects a register.
    localparam logic [5:0] OFS_OPERAND_A = 6'h00;
    localparam logic [5:0] OFS_OPERAND_B = 6'h08;
    localparam logic [5:0] OFS_OPSTART   = 6'h10;
    localparam logic [5:0] OFS_OPCLEAR   = 6'h18;
    localparam logic [5:0] OFS_OPDONE    = 6'h20;
    localparam logic [5:0] OFS_RESULT_H  = 6'h28;
    localparam logic [5:0] OFS_RESULT_L  = 6'h30;
    localparam logic [5:0] OFS_INTR_EN   = 6'h38;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    function automatic logic [5:0] reg_offset(input logic [2:0] word_sel);
        return {word_sel, 3'b000};
    endfunction

endpackage

// File: rtl/booth_mul64.sv
// Radix-2 Booth multiplier: one add/sub plus arithmetic shift per cycle,
// 64 steps per product, result registered on the final step.
module booth_mul64
    import mul_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         op_start,
    input  logic         op_clear,
    input  logic [63:0]  multiplicand,
    input  logic [63:0]  multiplier,
    output logic [127:0] result,
    output logic         op_done
);

    logic [63:0]  mcand_q, mcand_d;
    logic [63:0]  acc_q, acc_d;
    logic [63:0]  mplr_q, mplr_d;
    logic         qm1_q, qm1_d;
    logic [6:0]   cnt_q, cnt_d;
    logic         run_q, run_d;
    logic [127:0] result_q, result_d;

    logic [64:0]  sum;
    logic [63:0]  acc_step;
    logic [63:0]  mplr_step;
    logic         last_step;

    // The add/sub is done one bit wider so that a most-negative multiplicand
    // cannot overflow before the shift brings it back into 64 bits.
    always_comb begin
        sum = {acc_q[63], acc_q};
        case ({mplr_q[0], qm1_q})
            2'b01:   sum = {acc_q[63], acc_q} + {mcand_q[63], mcand_q};
            2'b10:   sum = {acc_q[63], acc_q} - {mcand_q[63], mcand_q};
            default: sum = {acc_q[63], acc_q};
        endcase
        acc_step  = sum[64:1];
        mplr_step = {sum[0], mplr_q[63:1]};
    end

    assign last_step = run_q && (cnt_q == 7'(MUL_STEPS - 1));
    assign op_done   = last_step;
    assign result    = result_q;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplr_d   = mplr_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        result_d = result_q;
        if (op_clear) begin
            mcand_d  = '0;
            acc_d    = '0;
            mplr_d   = '0;
            qm1_d    = 1'b0;
            cnt_d    = '0;
            run_d    = 1'b0;
            result_d = '0;
        end else if (op_start) begin
            mcand_d = multiplicand;
            acc_d   = '0;
            mplr_d  = multiplier;
            qm1_d   = 1'b0;
            cnt_d   = '0;
            run_d   = 1'b1;
        end else if (run_q) begin
            acc_d  = acc_step;
            mplr_d = mplr_step;
            qm1_d  = mplr_q[0];
            cnt_d  = cnt_q + 7'd1;
            if (last_step) begin
                run_d    = 1'b0;
                result_d = {acc_step, mplr_step};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplr_q   <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            result_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplr_q   <= mplr_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            result_q <= result_d;
        end
    end

endmodule

// File: rtl/mul_slave.sv
// Bus slave wrapping booth_mul64: register file, decode, read mux, control FSM
// and level interrupt.
module mul_slave
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        m_interrupt
);

    logic [63:0]  opa_q, opa_d;
    logic [63:0]  opb_q, opb_d;
    logic         intr_en_q, intr_en_d;
    mul_state_e   state_q, state_d;

    logic [5:0]   reg_ofs;
    logic         wr_en;
    logic         wr_start;
    logic         wr_clear;
    logic         op_start;
    logic         mul_done;
    logic [127:0] mul_result;
    logic         busy;
    logic         done;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^{s_addr[15:6], s_addr[2:0]};

    assign reg_ofs  = reg_offset(s_addr[5:3]);
    assign wr_en    = s_sel && s_wr;
    assign wr_start = wr_en && (reg_ofs == OFS_OPSTART) && s_din[0];
    assign wr_clear = wr_en && (reg_ofs == OFS_OPCLEAR) && s_din[0];
    // A start outside IDLE is dropped here so the datapath never restarts mid-run.
    assign op_start = wr_start && (state_q == ST_IDLE);

    booth_mul64 u_booth (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (wr_clear),
        .multiplicand (opa_q),
        .multiplier   (opb_q),
        .result       (mul_result),
        .op_done      (mul_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (wr_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (wr_start) state_d = ST_EXEC;
                ST_EXEC: if (mul_done) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == ST_EXEC);
        done = (state_q == ST_DONE);
    end

    assign m_interrupt = intr_en_q && done;

    always_comb begin
        opa_d     = opa_q;
        opb_d     = opb_q;
        intr_en_d = intr_en_q;
        if (wr_en) begin
            case (reg_ofs)
                OFS_OPERAND_A: opa_d     = s_din;
                OFS_OPERAND_B: opb_d     = s_din;
                OFS_INTR_EN:   intr_en_d = s_din[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q     <= '0;
            opb_q     <= '0;
            intr_en_q <= 1'b0;
        end else begin
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            intr_en_q <= intr_en_d;
        end
    end

    always_comb begin
        s_dout = '0;
        if (s_sel && !s_wr) begin
            case (reg_ofs)
                OFS_OPERAND_A: s_dout = opa_q;
                OFS_OPERAND_B: s_dout = opb_q;
                OFS_OPDONE:    s_dout = {62'b0, busy, done};
                OFS_RESULT_H:  s_dout = mul_result[127:64];
                OFS_RESULT_L:  s_dout = mul_result[63:0];
                OFS_INTR_EN:   s_dout = {63'b0, intr_en_q};
                default:       s_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_slave.sv
// Directed bench for mul_slave: bus tasks push expected {irq, dout} into a
// queue, a negedge monitor pops and compares whenever a check cycle is flagged.
module tb_mul_slave;
    import mul_pkg::*;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_sel = 1'b0;
    logic        s_wr = 1'b0;
    logic [15:0] s_addr = 16'h7000;
    logic [63:0] s_din = '0;
    logic [63:0] s_dout;
    logic        m_interrupt;

    logic [64:0] exp_q[$];
    string       name_q[$];
    logic        chk_req = 1'b0;
    logic        exp_irq = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    mul_slave dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_sel       (s_sel),
        .s_wr        (s_wr),
        .s_addr      (s_addr),
        .s_din       (s_din),
        .s_dout      (s_dout),
        .m_interrupt (m_interrupt)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (chk_req) begin
            logic [64:0] exp_v;
            logic [64:0] act_v;
            string       nm;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: check cycle with empty expected queue");
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {m_interrupt, s_dout};
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: got dout=%h irq=%b, expected dout=%h irq=%b",
                             nm, act_v[63:0], act_v[64], exp_v[63:0], exp_v[64]);
                end
            end
        end
    end

    // driver tasks; each starts and ends 1 time unit after a rising edge
    task automatic expect_val(input logic [63:0] v, input string nm);
        exp_q.push_back({exp_irq, v});
        name_q.push_back(nm);
        chk_req = 1'b1;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
        s_sel   = 1'b0;
        s_wr    = 1'b0;
        s_din   = '0;
    endtask

    task automatic bus_read(input logic [5:0] ofs, input logic [63:0] v, input string nm);
        s_sel  = 1'b1;
        s_wr   = 1'b0;
        s_addr = 16'h7000 | {10'h0, ofs};
        expect_val(v, nm);
        end_cycle();
    endtask

    task automatic bus_write(input logic [5:0] ofs, input logic [63:0] d);
        s_sel  = 1'b1;
        s_wr   = 1'b1;
        s_addr = 16'h7000 | {10'h0, ofs};
        s_din  = d;
        end_cycle();
    endtask

    task automatic bus_write_chk(input logic [5:0] ofs, input logic [63:0] d, input string nm);
        s_sel  = 1'b1;
        s_wr   = 1'b1;
        s_addr = 16'h7000 | {10'h0, ofs};
        s_din  = d;
        expect_val(64'h0, nm);
        end_cycle();
    endtask

    task automatic probe_unsel(input logic [5:0] ofs, input string nm);
        s_sel  = 1'b0;
        s_wr   = 1'b0;
        s_addr = 16'h7000 | {10'h0, ofs};
        expect_val(64'h0, nm);
        end_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) end_cycle();
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_h, input logic [63:0] exp_l, input string tag);
        bus_write(OFS_OPERAND_A, a);
        bus_write(OFS_OPERAND_B, b);
        bus_write(OFS_OPSTART, 64'h1);
        for (int i = 0; i < MUL_STEPS; i++) bus_read(OFS_OPDONE, 64'h2, {tag, "_busy"});
        bus_read(OFS_OPDONE, 64'h1, {tag, "_done"});
        bus_read(OFS_RESULT_H, exp_h, {tag, "_res_h"});
        bus_read(OFS_RESULT_L, exp_l, {tag, "_res_l"});
        bus_write(OFS_OPCLEAR, 64'h1);
        bus_read(OFS_OPDONE, 64'h0, {tag, "_cleared"});
        bus_read(OFS_RESULT_L, 64'h0, {tag, "_res_l_cleared"});
    endtask

    // directed sequence
    initial begin
        @(posedge clk);
        #1;
        bus_read(OFS_OPDONE,    64'h0, "rst_opdone");
        bus_read(OFS_RESULT_H,  64'h0, "rst_res_h");
        bus_read(OFS_RESULT_L,  64'h0, "rst_res_l");
        bus_read(OFS_OPERAND_A, 64'h0, "rst_opa");
        bus_read(OFS_INTR_EN,   64'h0, "rst_intr_en");
        reset_n = 1'b1;
        idle(2);

        run_op(64'd3, 64'd5, 64'h0, 64'hF, "pos");
        run_op(ALL1, 64'd1, ALL1, ALL1, "neg1");
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 64'h0, "minmin");
        run_op(64'd7, 64'hFFFF_FFFF_FFFF_FFF7, ALL1, 64'hFFFF_FFFF_FFFF_FFC1, "mixed");

        bus_read(OFS_OPERAND_A, 64'd7, "readback_a");
        bus_read(OFS_OPERAND_B, 64'hFFFF_FFFF_FFFF_FFF7, "readback_b");
        bus_read(OFS_OPSTART, 64'h0, "wo_opstart_reads_0");
        bus_read(OFS_OPCLEAR, 64'h0, "wo_opclear_reads_0");

        // abort at step 20
        bus_write(OFS_OPERAND_A, 64'd6);
        bus_write(OFS_OPERAND_B, 64'd7);
        bus_write(OFS_OPSTART, 64'h1);
        for (int i = 0; i < 20; i++) bus_read(OFS_OPDONE, 64'h2, "abort_busy");
        bus_write(OFS_OPCLEAR, 64'h1);
        bus_read(OFS_OPDONE,   64'h0, "abort_opdone");
        bus_read(OFS_RESULT_H, 64'h0, "abort_res_h");
        bus_read(OFS_RESULT_L, 64'h0, "abort_res_l");
        idle(70);
        bus_read(OFS_OPDONE,   64'h0, "abort_still_idle");
        bus_read(OFS_RESULT_L, 64'h0, "abort_res_stays_0");

        // restart with a redundant start and an operand write mid-run
        bus_write(OFS_OPSTART, 64'h1);
        for (int i = 0; i < MUL_STEPS; i++) begin
            if (i == 10)      bus_write(OFS_OPSTART, 64'h1);
            else if (i == 20) bus_write(OFS_OPERAND_A, 64'd99);
            else              bus_read(OFS_OPDONE, 64'h2, "restart_busy");
        end
        bus_read(OFS_OPDONE,    64'h1,  "restart_done");
        bus_read(OFS_RESULT_H,  64'h0,  "restart_res_h");
        bus_read(OFS_RESULT_L,  64'd42, "restart_res_l");
        bus_read(OFS_OPERAND_A, 64'd99, "restart_opa_updated");
        bus_write(OFS_OPCLEAR, 64'h1);

        // interrupt and decode
        bus_write(OFS_INTR_EN, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_read(OFS_INTR_EN, 64'h1, "intr_en_bit0_only");
        bus_write(OFS_OPERAND_A, 64'd2);
        bus_write(OFS_OPERAND_B, 64'd3);
        bus_write(OFS_OPSTART, 64'h1);
        for (int i = 0; i < MUL_STEPS; i++) bus_read(OFS_OPDONE, 64'h2, "irq_busy_low");
        exp_irq = 1'b1;
        bus_read(OFS_OPDONE,   64'h1, "irq_done");
        bus_read(OFS_RESULT_L, 64'd6, "irq_res_l");
        bus_write_chk(OFS_RESULT_L, 64'h1234, "write_cycle_dout_0");
        bus_read(OFS_RESULT_L, 64'd6, "ro_write_ignored");
        bus_read(OFS_RESULT_H, 64'h0, "irq_res_h");
        probe_unsel(OFS_RESULT_L, "unselected_dout_0");
        bus_write(OFS_OPCLEAR, 64'h1);
        exp_irq = 1'b0;
        bus_read(OFS_OPDONE,    64'h0, "irq_cleared");
        bus_read(OFS_INTR_EN,   64'h1, "clear_keeps_intr_en");
        bus_read(OFS_OPERAND_A, 64'd2, "clear_keeps_opa");

        // asynchronous reset in the middle of a run
        bus_write(OFS_OPSTART, 64'h1);
        for (int i = 0; i < 30; i++) bus_read(OFS_OPDONE, 64'h2, "prereset_busy");
        reset_n = 1'b0;
        bus_read(OFS_OPDONE,    64'h0, "async_rst_opdone");
        bus_read(OFS_RESULT_H,  64'h0, "async_rst_res_h");
        bus_read(OFS_RESULT_L,  64'h0, "async_rst_res_l");
        bus_read(OFS_INTR_EN,   64'h0, "async_rst_intr_en");
        bus_read(OFS_OPERAND_A, 64'h0, "async_rst_opa");
        reset_n = 1'b1;
        idle(3);
        bus_read(OFS_OPDONE, 64'h0, "post_rst_idle");
        run_op(64'd3, 64'd5, 64'h0, 64'hF, "post_rst");

        idle(2);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_slave.md
# mul_slave

Memory-mapped 64×64 signed multiplier accelerator, the slave on the bus's `s1_sel` port (window 0x7000–0x71FF). It consumes the bus's slave-side outputs (`s_addr`, `s_din`, `s_wr`) and returns read data on `s_dout`, which the bus forwards to the master. The master loads operands, starts the operation, and polls status or takes an interrupt. The result is read back as two 64-bit words.

## Interface
- No parameters. Fixed: data 64 bits, address 16 bits, 64 iteration cycles.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_sel` in 1: slave select from the bus (`s1_sel`).
- `s_wr` in 1: 1 = write, 0 = read; valid only while `s_sel`=1.
- `s_addr` in 16: byte address; only `s_addr[5:3]` is decoded (offset within the window).
- `s_din` in 64: write data.
- `s_dout` out 64: read data to the bus.
- `m_interrupt` out 1: level interrupt, equals `INTR_EN[0]` AND done.

## Operation
- Register map (offset = `s_addr[5:0]`):
  - 0x00 `OPERAND_A`: RW.
  - 0x08 `OPERAND_B`: RW.
  - 0x10 `OPSTART`: WO; bit0=1 starts an operation.
  - 0x18 `OPCLEAR`: WO; bit0=1 clears.
  - 0x20 `OPDONE`: RO; bit0 = done, bit1 = busy, bits[63:2] = 0.
  - 0x28 `RESULT_H`: RO.
  - 0x30 `RESULT_L`: RO.
  - 0x38 `INTR_EN`: RW; bit0 only, bits[63:1] read 0.
- Writes take effect on the edge when `s_sel`=1 and `s_wr`=1. Writes to RO offsets are ignored. Reads of WO offsets return 0.
- Reads are combinational. `s_dout` = the selected register when `s_sel`=1 and `s_wr`=0; otherwise 64'h0.
- FSM states and transitions:
  - IDLE → EXEC on an `OPSTART` bit0 write. A and B are copied into internal working registers. The counter is set to 0.
  - EXEC: one radix-2 Booth step per cycle (add/sub multiplicand at bits[127:64], then arithmetic shift right of the 129-bit {acc, Q, q-1}). The counter increments each step.
  - EXEC → DONE after step 64. `{RESULT_H, RESULT_L}` is loaded with the signed 128-bit product.
  - DONE holds until `OPCLEAR`.
  - `OPCLEAR` in any state → IDLE. It zeroes RESULT_H/L, done, busy and the counter. `OPERAND_A/B` and `INTR_EN` are unchanged.
- Arithmetic: two's-complement signed. The product is exact over 128 bits; no overflow is possible.
- Boundary cases:
  - `OPSTART` while in EXEC or DONE is ignored.
  - `OPSTART` and `OPCLEAR` cannot coincide (distinct offsets).
  - Operand writes during EXEC update `OPERAND_A/B` but do not affect the running operation.
  - `OPCLEAR` mid-EXEC aborts the operation; RESULT stays 0.
  - Asynchronous reset at any point: everything returns to reset state immediately.
- Reset values: all registers, result, counter and `m_interrupt` = 0; FSM = IDLE; `s_dout` = 0.

## Timing
- Start written at edge T0: from T0 the state is EXEC and `OPDONE` reads 2'b10.
- Steps occur at edges T1..T64. At T64 the state is DONE, the result is valid, `OPDONE` reads 2'b01, and `m_interrupt` rises if enabled.
- Start-to-done latency: 64 cycles.
- Read latency is 0 cycles (combinational through the bus to the master).
- Write-to-readback: visible in the cycle after the write edge.
- `OPCLEAR` at edge Tc: IDLE and zero result from Tc; `m_interrupt` falls at Tc.

## Structure
- Shared package `mul_pkg`:
  - offset constants `OFS_OPERAND_A` … `OFS_INTR_EN`;
  - state encoding `ST_IDLE`=2'b00, `ST_EXEC`=2'b01, `ST_DONE`=2'b10;
  - `MUL_STEPS`=64.
- Sub-module `booth_mul64`. It holds the datapath plus the step counter, with ports `clk`, `reset_n`, `op_start`, `op_clear`, `multiplicand`, `multiplier` (in), and `result[127:0]`, `op_done` (out).
- `mul_slave` contains the register file, address decode, read mux, FSM and interrupt logic.

## Test plan
- **Reset:** assert `reset_n`=0 mid-EXEC → `s_dout`, `m_interrupt`, `OPDONE`, RESULT_H/L all read 0 immediately, and the FSM is in IDLE.
- **Positive product:** A=3, B=5, start, poll → `OPDONE` reads 2 for 64 cycles, then 1; RESULT_H=0, RESULT_L=0xF.
- **Signed product:** A=64'hFFFF_FFFF_FFFF_FFFF (−1), B=1 → RESULT_H = RESULT_L = 64'hFFFF_FFFF_FFFF_FFFF.
- **Extreme operands:** A=B=64'h8000_0000_0000_0000 → RESULT_H=64'h4000_0000_0000_0000, RESULT_L=0. Also A=7, B=−9 → RESULT_H=all ones, RESULT_L=64'hFFFF_FFFF_FFFF_FFC1.
- **Clear during EXEC, then restart:** clear at step 20 → `OPDONE`=0 and RESULT=0. A second start ignored during EXEC leaves latency at 64. Writing A during EXEC does not change that result.
- **Interrupt and decode:**
  - `INTR_EN`=1, run 2×3 → `m_interrupt`=1 exactly from T64 until `OPCLEAR`.
  - With `s_sel`=0, or on a write cycle, `s_dout`=0.
  - A write to `RESULT_L` has no effect.
